// File: rtl/gpio_cfg_pkg.sv
// Shared constants for the GPIO pad configuration controller: word layout,
// reset configuration and bit-counter sizing.
package gpio_cfg_pkg;

    localparam int unsigned CFG_W = 13;
    localparam logic [CFG_W-1:0] RESET_CFG = 13'h1803;

    localparam int unsigned CFG_MGMT_ENA    = 0;
    localparam int unsigned CFG_OUT_DIS     = 1;
    localparam int unsigned CFG_HLD_OVR     = 2;
    localparam int unsigned CFG_IB_MODE_SEL = 3;
    localparam int unsigned CFG_INP_DIS     = 4;
    localparam int unsigned CFG_VTRIP_SEL   = 5;
    localparam int unsigned CFG_SLOW        = 6;
    localparam int unsigned CFG_ANALOG_EN   = 7;
    localparam int unsigned CFG_ANALOG_SEL  = 8;
    localparam int unsigned CFG_ANALOG_POL  = 9;
    localparam int unsigned CFG_DM_LSB      = 10;
    localparam int unsigned CFG_DM_MSB      = 12;

    localparam int unsigned CNT_W = $clog2(CFG_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);

endpackage

// File: rtl/gpio_cfg_shift.sv
// Serial configuration shift register with saturating bit counter; commits the
// shifted word on a load strobe only when a complete frame has been received.
module gpio_cfg_shift
    import gpio_cfg_pkg::*;
(
    input  logic             serial_clock,
    input  logic             resetn,
    input  logic             serial_data_in,
    input  logic             serial_shift_en,
    input  logic             serial_load,
    output logic [CFG_W-1:0] cfg,
    output logic             serial_data_out,
    output logic             cfg_err
);

    logic [CFG_W-1:0] shreg;
    logic [CNT_W-1:0] bit_cnt;

    // NOTE: the shift register is reset too, so serial_data_out is defined
    // downstream in the chain from the first cycle after reset.
    always_ff @(posedge serial_clock or negedge resetn) begin
        if (!resetn) begin
            shreg   <= '0;
            bit_cnt <= '0;
            cfg     <= RESET_CFG;
            cfg_err <= 1'b0;
        end else if (serial_load) begin
            // Load wins over a coincident shift; the frame counter always restarts.
            bit_cnt <= '0;
            if (bit_cnt == CNT_FULL) begin
                cfg     <= shreg;
                cfg_err <= 1'b0;
            end else begin
                cfg_err <= 1'b1;
            end
        end else if (serial_shift_en) begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            shreg <= {shreg[CFG_W-2:0], serial_data_in};
            if (bit_cnt != CNT_FULL) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    assign serial_data_out = shreg[CFG_W-1];

endmodule

// File: rtl/gpio_pad_cfg_ctrl.sv
// Per-pad controller: decodes the committed configuration onto the pad
// controls and steers pad data between the management core and user project.
module gpio_pad_cfg_ctrl
    import gpio_cfg_pkg::*;
(
    input  logic       serial_clock,
    input  logic       resetn,
    input  logic       serial_data_in,
    input  logic       serial_shift_en,
    input  logic       serial_load,
    output logic       serial_data_out,
    output logic       cfg_err,
    input  logic       mgmt_gpio_out,
    input  logic       mgmt_gpio_oe,
    output logic       mgmt_gpio_in,
    input  logic       user_gpio_out,
    input  logic       user_gpio_oe_n,
    output logic       user_gpio_in,
    input  logic       pad_in,
    output logic       pad_out,
    output logic       pad_oe_n,
    output logic [2:0] pad_dm,
    output logic       pad_hld_ovr,
    output logic       pad_ib_mode_sel,
    output logic       pad_inp_dis,
    output logic       pad_vtrip_sel,
    output logic       pad_slow,
    output logic       pad_analog_en,
    output logic       pad_analog_sel,
    output logic       pad_analog_pol
);

    logic [CFG_W-1:0] cfg;
    logic             pad_in_s1;
    logic             pad_in_s2;

    gpio_cfg_shift u_shift (
        .serial_clock    (serial_clock),
        .resetn          (resetn),
        .serial_data_in  (serial_data_in),
        .serial_shift_en (serial_shift_en),
        .serial_load     (serial_load),
        .cfg             (cfg),
        .serial_data_out (serial_data_out),
        .cfg_err         (cfg_err)
    );

    // The pad input is asynchronous to serial_clock on the management side.
    always_ff @(posedge serial_clock or negedge resetn) begin
        if (!resetn) begin
            pad_in_s1 <= 1'b0;
            pad_in_s2 <= 1'b0;
        end else begin
            pad_in_s1 <= pad_in;
            pad_in_s2 <= pad_in_s1;
        end
    end

    assign pad_dm          = cfg[CFG_DM_MSB:CFG_DM_LSB];
    assign pad_hld_ovr     = cfg[CFG_HLD_OVR];
    assign pad_ib_mode_sel = cfg[CFG_IB_MODE_SEL];
    assign pad_inp_dis     = cfg[CFG_INP_DIS];
    assign pad_vtrip_sel   = cfg[CFG_VTRIP_SEL];
    assign pad_slow        = cfg[CFG_SLOW];
    assign pad_analog_en   = cfg[CFG_ANALOG_EN];
    assign pad_analog_sel  = cfg[CFG_ANALOG_SEL];
    assign pad_analog_pol  = cfg[CFG_ANALOG_POL];

    always_comb begin
        // NOTE: defaults first so no path through this block can infer a latch.
        pad_out      = user_gpio_out;
        pad_oe_n     = cfg[CFG_OUT_DIS] | user_gpio_oe_n;
        mgmt_gpio_in = 1'b0;
        user_gpio_in = pad_in & ~cfg[CFG_INP_DIS];
        if (cfg[CFG_MGMT_ENA]) begin
            pad_out      = mgmt_gpio_out;
            pad_oe_n     = cfg[CFG_OUT_DIS] | ~mgmt_gpio_oe;
            mgmt_gpio_in = pad_in_s2 & ~cfg[CFG_INP_DIS];
            user_gpio_in = 1'b0;
        end
    end

endmodule

// File: tb/tb_gpio_pad_cfg_ctrl.sv
// Scoreboard bench for gpio_pad_cfg_ctrl: a behavioural model pushes expected
// outputs after each clock edge and they are popped and compared mid-cycle.
module tb_gpio_pad_cfg_ctrl;
    import gpio_cfg_pkg::*;

    logic       serial_clock = 1'b0;
    logic       resetn;
    logic       serial_data_in, serial_shift_en, serial_load;
    logic       serial_data_out, cfg_err;
    logic       mgmt_gpio_out, mgmt_gpio_oe, mgmt_gpio_in;
    logic       user_gpio_out, user_gpio_oe_n, user_gpio_in;
    logic       pad_in, pad_out, pad_oe_n;
    logic [2:0] pad_dm;
    logic       pad_hld_ovr, pad_ib_mode_sel, pad_inp_dis, pad_vtrip_sel;
    logic       pad_slow, pad_analog_en, pad_analog_sel, pad_analog_pol;

    gpio_pad_cfg_ctrl dut (
        .serial_clock    (serial_clock),
        .resetn          (resetn),
        .serial_data_in  (serial_data_in),
        .serial_shift_en (serial_shift_en),
        .serial_load     (serial_load),
        .serial_data_out (serial_data_out),
        .cfg_err         (cfg_err),
        .mgmt_gpio_out   (mgmt_gpio_out),
        .mgmt_gpio_oe    (mgmt_gpio_oe),
        .mgmt_gpio_in    (mgmt_gpio_in),
        .user_gpio_out   (user_gpio_out),
        .user_gpio_oe_n  (user_gpio_oe_n),
        .user_gpio_in    (user_gpio_in),
        .pad_in          (pad_in),
        .pad_out         (pad_out),
        .pad_oe_n        (pad_oe_n),
        .pad_dm          (pad_dm),
        .pad_hld_ovr     (pad_hld_ovr),
        .pad_ib_mode_sel (pad_ib_mode_sel),
        .pad_inp_dis     (pad_inp_dis),
        .pad_vtrip_sel   (pad_vtrip_sel),
        .pad_slow        (pad_slow),
        .pad_analog_en   (pad_analog_en),
        .pad_analog_sel  (pad_analog_sel),
        .pad_analog_pol  (pad_analog_pol)
    );

    always #5 serial_clock = ~serial_clock;

    typedef struct {
        logic [10:0] ctrl;
        logic        pad_out;
        logic        pad_oe_n;
        logic        err;
        logic        sdo;
        logic        mgmt_in;
        logic        user_in;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [CFG_W-1:0] m_sh, m_cfg;
    int               m_cnt;
    logic             m_err, m_s1, m_s2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sh  = '0;
        m_cfg = RESET_CFG;
        m_cnt = 0;
        m_err = 1'b0;
        m_s1  = 1'b0;
        m_s2  = 1'b0;
    endtask

    function automatic exp_t expected();
        exp_t e;
        logic ena, dis;
        ena       = m_cfg[0];
        dis       = m_cfg[4];
        e.ctrl    = m_cfg[12:2];
        e.pad_out = ena ? mgmt_gpio_out : user_gpio_out;
        e.pad_oe_n = m_cfg[1] | (ena ? ~mgmt_gpio_oe : user_gpio_oe_n);
        e.err     = m_err;
        e.sdo     = m_sh[12];
        e.mgmt_in = ena & ~dis & m_s2;
        e.user_in = ~ena & ~dis & pad_in;
        return e;
    endfunction

    task automatic compare_front(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_ctrl"}, {pad_dm, pad_analog_pol, pad_analog_sel, pad_analog_en,
                  pad_slow, pad_vtrip_sel, pad_inp_dis, pad_ib_mode_sel, pad_hld_ovr}, e.ctrl);
            check({tag, "_pad_out"},  pad_out,         e.pad_out);
            check({tag, "_pad_oe_n"}, pad_oe_n,        e.pad_oe_n);
            check({tag, "_cfg_err"},  cfg_err,         e.err);
            check({tag, "_sdo"},      serial_data_out, e.sdo);
            check({tag, "_mgmt_in"},  mgmt_gpio_in,    e.mgmt_in);
            check({tag, "_user_in"},  user_gpio_in,    e.user_in);
        end
    endtask

    // One clock cycle: drive at the falling edge, model the rising edge, check at the next falling edge.
    task automatic step(input string tag, input logic din, input logic sh_en, input logic ld);
        serial_data_in  = din;
        serial_shift_en = sh_en;
        serial_load     = ld;
        mgmt_gpio_out   = 1'($urandom);
        mgmt_gpio_oe    = 1'($urandom);
        user_gpio_out   = 1'($urandom);
        user_gpio_oe_n  = 1'($urandom);
        pad_in          = 1'($urandom);
        @(posedge serial_clock);
        m_s2 = m_s1;
        m_s1 = pad_in;
        if (ld) begin
            if (m_cnt == CFG_W) begin
                m_cfg = m_sh;
                m_err = 1'b0;
            end else begin
                m_err = 1'b1;
            end
            m_cnt = 0;
        end else if (sh_en) begin
            m_sh = {m_sh[CFG_W-2:0], din};
            if (m_cnt < CFG_W) m_cnt++;
        end
        sb.push_back(expected());
        @(negedge serial_clock);
        compare_front(tag);
    endtask

    task automatic shift_bits(input string tag, input logic [CFG_W-1:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) step(tag, val[i], 1'b1, 1'b0);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn          = 1'b0;
        serial_data_in  = 1'b0;
        serial_shift_en = 1'b0;
        serial_load     = 1'b0;
        mgmt_gpio_out   = 1'b1;
        mgmt_gpio_oe    = 1'b1;
        user_gpio_out   = 1'b0;
        user_gpio_oe_n  = 1'b0;
        pad_in          = 1'b1;
        model_reset();
        repeat (2) @(negedge serial_clock);
        check("reset_pad_dm",   pad_dm,          3'b110);
        check("reset_pad_oe_n", pad_oe_n,        1'b1);
        check("reset_pad_out",  pad_out,         1'b1);
        check("reset_cfg_err",  cfg_err,         1'b0);
        check("reset_sdo",      serial_data_out, 1'b0);
        check("reset_mgmt_in",  mgmt_gpio_in,    1'b0);
        resetn = 1'b1;
        sb.push_back(expected());
        compare_front("post_reset");

        idle("mgmt_sync", 6);

        shift_bits("user_frame", 13'h0C00, CFG_W);
        step("user_load", 1'b0, 1'b0, 1'b1);
        check("user_pad_dm", pad_dm, 3'b011);
        idle("user_mode", 8);

        shift_bits("short_frame", 13'h1FFF, CFG_W - 1);
        step("short_load", 1'b0, 1'b0, 1'b1);
        check("short_err", cfg_err, 1'b1);
        shift_bits("inpdis_frame", 13'h0011, CFG_W);
        step("inpdis_load", 1'b0, 1'b0, 1'b1);
        idle("inpdis_mode", 6);

        shift_bits("over_a", 13'h15A5, CFG_W);
        shift_bits("over_b", 13'h0A49, CFG_W);
        step("over_load", 1'b0, 1'b0, 1'b1);
        idle("mgmt_mode", 10);

        shift_bits("prio_frame", 13'h1FFE, CFG_W);
        step("prio_both", 1'b0, 1'b1, 1'b1);
        step("prio_reload", 1'b0, 1'b0, 1'b1);
        check("prio_count_cleared", cfg_err, 1'b1);
        shift_bits("prio_drain", 13'h0000, CFG_W);

        shift_bits("mid_frame", 13'h1F1F, 5);
        resetn = 1'b0;
        model_reset();
        sb.push_back(expected());
        #1;
        compare_front("async_reset");
        check("async_reset_pad_dm", pad_dm, 3'b110);
        @(posedge serial_clock);
        #2;
        resetn = 1'b1;
        @(negedge serial_clock);
        step("after_reset_load", 1'b0, 1'b0, 1'b1);
        idle("after_reset", 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
